// File: rtl/pe_kl_issuer_if.sv
// Lock-key bus bundle between the PE array controller and the issuer.
// master = issuer side, slave = host / PE-array side.
interface pe_kl_issuer_if #(
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int ROW_W = 2,
    parameter int COL_W = 2
);
    localparam int N         = ROWS * COLS;
    localparam int BUS_WIDTH = ROW_W + COL_W;
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;

    logic                 init_start;
    logic                 init_done;
    logic                 busy;
    logic [N-1:0]         set_vec;
    logic                 kl_type;
    logic [BUS_WIDTH-1:0] kl_data;
    logic                 key_valid;
    logic                 key_ready;
    logic [ROW_W-1:0]     key_row;
    logic [COL_W-1:0]     key_col;
    logic [N-1:0]         kl_valid_vec;
    logic                 res_valid;
    logic                 res_hit;
    logic                 res_multi;
    logic [IDX_W-1:0]     res_idx;

    modport master (
        input  init_start, key_valid, key_row, key_col, kl_valid_vec,
        output init_done, busy, set_vec, kl_type, kl_data, key_ready,
               res_valid, res_hit, res_multi, res_idx
    );

    modport slave (
        output init_start, key_valid, key_row, key_col, kl_valid_vec,
        input  init_done, busy, set_vec, kl_type, kl_data, key_ready,
               res_valid, res_hit, res_multi, res_idx
    );
endinterface

// File: rtl/pe_kl_issuer.sv
// Purpose: sweeps {row,col} lock tags into the PE array, then broadcasts keys and grades KL_VALID.
// Latency: result pulse two edges after the key handshake edge; key held KEY_HOLD more cycles.
// Backpressure: key_ready high only in READY; one key in flight, next accepted 3+KEY_HOLD edges later.
module pe_kl_issuer #(
    parameter int                        ROWS     = 3,
    parameter int                        COLS     = 3,
    parameter int                        ROW_W    = 2,
    parameter int                        COL_W    = 2,
    parameter logic [ROW_W+COL_W-1:0]    IDLE_KEY = '1,
    parameter int                        KEY_HOLD = 2
) (
    input  logic           clk,
    input  logic           rst,
    pe_kl_issuer_if.master io
);
    localparam int N         = ROWS * COLS;
    localparam int BUS_WIDTH = ROW_W + COL_W;
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_W    = $clog2(KEY_HOLD + 2);
    localparam logic [N-1:0] VEC_ONE = N'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOCK, S_READY, S_KEY_DRV, S_KEY_CHK, S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [BUS_WIDTH-1:0] key_q, key_d;
    logic [N-1:0]         set_vec_q, set_vec_d;
    logic                 kl_type_q, kl_type_d;
    logic [BUS_WIDTH-1:0] kl_data_q, kl_data_d;
    logic                 init_done_q, init_done_d;
    logic                 busy_q, busy_d;
    logic                 key_ready_q, key_ready_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_hit_q, res_hit_d;
    logic                 res_multi_q, res_multi_d;
    logic [IDX_W-1:0]     res_idx_q, res_idx_d;

    logic                 start_lock;
    logic                 go_ready;
    int                   match_cnt;
    int                   key_r;
    int                   key_c;
    logic [IDX_W-1:0]     low_idx;
    logic                 addr_bit;

    function automatic logic [BUS_WIDTH-1:0] tag_of(input logic [IDX_W-1:0] idx);
        int i;
        i = int'(idx);
        return {ROW_W'(i / COLS), COL_W'(i % COLS)};
    endfunction

    // Grade the returned KL_VALID vector against the key currently on the bus.
    always_comb begin
        match_cnt = 0;
        low_idx   = '0;
        addr_bit  = 1'b0;
        key_r     = int'(key_q[BUS_WIDTH-1 -: ROW_W]);
        key_c     = int'(key_q[COL_W-1:0]);
        for (int i = N - 1; i >= 0; i--) begin
            if (io.kl_valid_vec[i]) begin
                match_cnt = match_cnt + 1;
                low_idx   = IDX_W'(i);
            end
            if (key_r < ROWS && key_c < COLS && i == key_r * COLS + key_c) begin
                addr_bit = io.kl_valid_vec[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        key_d       = key_q;
        set_vec_d   = '0;
        kl_type_d   = kl_type_q;
        kl_data_d   = kl_data_q;
        init_done_d = 1'b0;
        res_valid_d = 1'b0;
        res_hit_d   = res_hit_q;
        res_multi_d = res_multi_q;
        res_idx_d   = res_idx_q;
        start_lock  = 1'b0;
        go_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (io.init_start) start_lock = 1'b1;
            end
            S_LOCK: begin
                if (idx_q == IDX_W'(N - 1)) begin
                    go_ready    = 1'b1;
                    init_done_d = 1'b1;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    set_vec_d = VEC_ONE << idx_d;
                    kl_data_d = tag_of(idx_d);
                end
            end
            S_READY: begin
                // A restart request wins over a key offered in the same cycle.
                if (io.init_start) begin
                    start_lock = 1'b1;
                end else if (io.key_valid) begin
                    key_d     = {io.key_row, io.key_col};
                    kl_type_d = 1'b1;
                    kl_data_d = {io.key_row, io.key_col};
                    state_d   = S_KEY_DRV;
                end
            end
            S_KEY_DRV: begin
                state_d = S_KEY_CHK;
            end
            S_KEY_CHK: begin
                res_valid_d = 1'b1;
                res_multi_d = (match_cnt > 1);
                res_hit_d   = (match_cnt == 1) && addr_bit;
                res_idx_d   = low_idx;
                if (KEY_HOLD == 0) begin
                    go_ready = 1'b1;
                end else begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_W'(KEY_HOLD - 1)) go_ready = 1'b1;
                else                                 hold_d   = hold_q + HOLD_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (start_lock) begin
            state_d   = S_LOCK;
            idx_d     = '0;
            set_vec_d = VEC_ONE;
            kl_type_d = 1'b0;
            kl_data_d = tag_of('0);
        end
        if (go_ready) begin
            state_d   = S_READY;
            kl_type_d = 1'b1;
            kl_data_d = IDLE_KEY;
        end

        key_ready_d = (state_d == S_READY);
        busy_d      = (state_d inside {S_LOCK, S_KEY_DRV, S_KEY_CHK, S_HOLD});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            key_q       <= '0;
            set_vec_q   <= '0;
            kl_type_q   <= 1'b1;
            kl_data_q   <= IDLE_KEY;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_multi_q <= 1'b0;
            res_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            key_q       <= key_d;
            set_vec_q   <= set_vec_d;
            kl_type_q   <= kl_type_d;
            kl_data_q   <= kl_data_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            key_ready_q <= key_ready_d;
            res_valid_q <= res_valid_d;
            res_hit_q   <= res_hit_d;
            res_multi_q <= res_multi_d;
            res_idx_q   <= res_idx_d;
        end
    end

    assign io.set_vec   = set_vec_q;
    assign io.kl_type   = kl_type_q;
    assign io.kl_data   = kl_data_q;
    assign io.init_done = init_done_q;
    assign io.busy      = busy_q;
    assign io.key_ready = key_ready_q;
    assign io.res_valid = res_valid_q;
    assign io.res_hit   = res_hit_q;
    assign io.res_multi = res_multi_q;
    assign io.res_idx   = res_idx_q;
endmodule

// File: tb/tb_pe_kl_issuer.sv
// Bench for pe_kl_issuer: 3x3 PE lock models, directed keys, scoreboard-checked results.
`timescale 1ns/1ps
module tb_pe_kl_issuer;
    localparam int ROWS = 3, COLS = 3, ROW_W = 2, COL_W = 2, KEY_HOLD = 2;
    localparam int N = ROWS * COLS, BW = ROW_W + COL_W, IDX_W = $clog2(N);
    localparam int RES_LAT = 2;   // handshake edge -> KEY_DRV edge -> KEY_CHK edge -> result

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_kl_issuer_if #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

    pe_kl_issuer #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
                   .IDLE_KEY('1), .KEY_HOLD(KEY_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    // PE models: capture lock on strobe, register key compare each cycle.
    logic [BW-1:0] lock_tag [N];
    logic [N-1:0]  lock_set   = '0;
    logic [N-1:0]  pe_match   = '0;
    logic [N-1:0]  force_mask = '0;
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.set_vec[i] && !bus.kl_type) begin
                lock_tag[i] <= bus.kl_data;
                lock_set[i] <= 1'b1;
            end
            pe_match[i] <= bus.kl_type && lock_set[i] && (bus.kl_data == lock_tag[i]);
        end
    end
    assign bus.kl_valid_vec = pe_match | force_mask;

    typedef struct {
        logic             hit;
        logic             multi;
        logic [IDX_W-1:0] idx;
        logic [N-1:0]     vec;
        int               hs_cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    logic [N-1:0] prev_vec = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard whenever a result pulse appears.
    always @(negedge clk) begin
        if (rst && bus.res_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL res_unexpected: res_valid high with nothing outstanding (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("res_hit",      bus.res_hit,      mon_e.hit);
                check("res_multi",    bus.res_multi,    mon_e.multi);
                check("res_idx",      bus.res_idx,      mon_e.idx);
                check("kl_valid_vec", prev_vec,         mon_e.vec);
                check("res_latency",  cyc - mon_e.hs_cyc, RES_LAT);
            end
        end
        prev_vec = bus.kl_valid_vec;
    end

    task automatic push_exp(input logic hit, input logic multi, input int idx, input logic [N-1:0] vec);
        exp_t e;
        e.hit = hit; e.multi = multi; e.idx = IDX_W'(idx); e.vec = vec;
        e.hs_cyc = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(output bit ok);
        int t = 0;
        while (bus.key_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = (bus.key_ready === 1'b1);
        if (!ok) begin
            n_chk++;
            $display("FAIL key_ready_timeout: key_ready=%b after %0d cycles, required 1", bus.key_ready, t);
        end
    endtask

    task automatic drain();
        int t = 0;
        bit ok;
        while (sb_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL result_timeout: %0d results outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        wait_ready(ok);
    endtask

    task automatic send_key(input int row, input int col, input logic hit, input logic multi,
                            input int idx, input logic [N-1:0] vec);
        bit ok;
        @(negedge clk);
        bus.key_row   = ROW_W'(row);
        bus.key_col   = COL_W'(col);
        bus.key_valid = 1'b1;
        wait_ready(ok);
        if (ok) push_exp(hit, multi, idx, vec);
        @(negedge clk);
        bus.key_valid = 1'b0;
        drain();
    endtask

    // Lock sweep; optionally keeps init_start high into LOCK or offers a key alongside the start.
    task automatic sweep(input bit hold_start, input bit with_key);
        logic [BW-1:0] tags [N];
        tags = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};
        @(negedge clk);
        bus.init_start = 1'b1;
        if (with_key) begin
            bus.key_row = 2'd1; bus.key_col = 2'd2; bus.key_valid = 1'b1;
        end
        @(negedge clk);
        if (!hold_start) bus.init_start = 1'b0;
        bus.key_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("sweep_set_vec[%0d]", i), bus.set_vec, 32'(1) << i);
            check($sformatf("sweep_kl_data[%0d]", i), bus.kl_data, tags[i]);
            check($sformatf("sweep_kl_type[%0d]", i), bus.kl_type, 0);
            check($sformatf("sweep_busy[%0d]", i),    bus.busy, 1);
            check($sformatf("sweep_ready[%0d]", i),   bus.key_ready, 0);
            if (i == 2) bus.init_start = 1'b0;
            @(negedge clk);
        end
        check("sweep_end_set_vec", bus.set_vec, 0);
        check("sweep_end_kl_type", bus.kl_type, 1);
        check("sweep_end_kl_data", bus.kl_data, 4'hF);
        check("sweep_init_done",   bus.init_done, 1);
        check("sweep_end_ready",   bus.key_ready, 1);
        check("sweep_end_busy",    bus.busy, 0);
        @(negedge clk);
        check("init_done_pulse",   bus.init_done, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_set_vec"},   bus.set_vec, 0);
        check({tag, "_kl_type"},   bus.kl_type, 1);
        check({tag, "_kl_data"},   bus.kl_data, 4'hF);
        check({tag, "_init_done"}, bus.init_done, 0);
        check({tag, "_busy"},      bus.busy, 0);
        check({tag, "_key_ready"}, bus.key_ready, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int prev_hs;
        int hs;
        bit ok;
        int b2b_row [3];
        int b2b_col [3];
        int b2b_idx [3];
        b2b_row = '{0, 2, 1};
        b2b_col = '{1, 0, 0};
        b2b_idx = '{1, 6, 3};

        bus.init_start = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_row    = '0;
        bus.key_col    = '0;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("idle");

        sweep(1'b0, 1'b0);

        send_key(1, 2, 1'b1, 1'b0, 5, 9'h020);
        check("res_hold_valid", bus.res_valid, 0);
        check("res_hold_hit",   bus.res_hit, 1);
        check("res_hold_idx",   bus.res_idx, 5);
        check("idle_key_after", bus.kl_data, 4'hF);

        send_key(3, 0, 1'b0, 1'b0, 0, 9'h000);
        send_key(0, 0, 1'b1, 1'b0, 0, 9'h001);
        send_key(2, 2, 1'b1, 1'b0, 8, 9'h100);

        force_mask = 9'h040;
        send_key(1, 1, 1'b0, 1'b1, 4, 9'h050);
        force_mask = 9'h00C;
        send_key(3, 3, 1'b0, 1'b1, 2, 9'h00C);
        force_mask = 9'h008;
        send_key(0, 3, 1'b0, 1'b0, 3, 9'h008);
        force_mask = '0;

        // key_valid held high across three transfers.
        prev_hs = 0;
        bus.key_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.key_row = ROW_W'(b2b_row[k]);
            bus.key_col = COL_W'(b2b_col[k]);
            wait_ready(ok);
            if (!ok) break;
            push_exp(1'b1, 1'b0, b2b_idx[k], 9'(32'(1) << b2b_idx[k]));
            hs = cyc + 1;
            if (k > 0) check("b2b_spacing", hs - prev_hs, 3 + KEY_HOLD);
            prev_hs = hs;
            @(negedge clk);
        end
        bus.key_valid = 1'b0;
        drain();

        sweep(1'b0, 1'b1);
        send_key(2, 1, 1'b1, 1'b0, 7, 9'h080);

        // Reset in the 5th LOCK cycle.
        @(negedge clk);
        bus.init_start = 1'b1;
        @(negedge clk);
        bus.init_start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_reset_pre_set_vec", bus.set_vec, 9'h010);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst = 1'b1;
        sweep(1'b1, 1'b0);
        send_key(1, 2, 1'b1, 1'b0, 5, 9'h020);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
